hazard_forward_unit: RTL and testbench

//  Producer of the 2-bit operand-forward selects consumed by the EX-stage operand muxes, plus load-use and branch-in-ID stall control.

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hazard_match.sv | 16 +
 rtl/hazard_forward_unit.sv | 88 ++++++++
 tb/tb_hazard_forward_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard/forwarding unit: forward-select
// codes, the zero register, and the per-stage tracking records.
package hazard_pkg;

   localparam logic [1:0] FWD_NONE  = 2'd0;
   localparam logic [1:0] FWD_WB    = 2'd1;
   localparam logic [1:0] FWD_EXMEM = 2'd2;
   localparam logic [4:0] REG_ZERO  = 5'd0;

   // Instruction sitting in EX: memread distinguishes loads for load-use.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
      logic       memread;
   } stage_info_t;

   // MEM only needs write-back identity; its load data is already forwardable.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       regwrite;
   } mem_info_t;

   // Nearest producer wins: EX/MEM result is newer than the WB value.
   function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
      if (ex_hit)
         return FWD_EXMEM;
      else if (mem_hit)
         return FWD_WB;
      else
         return FWD_NONE;
   endfunction

endpackage

// File: rtl/hazard_match.sv
// One producer/consumer comparison: does the tracked stage write the register
// the ID instruction reads? Register 0 is hardwired and never matches.
module hazard_match
   import hazard_pkg::*;
(
   input  logic       valid,
   input  logic [4:0] rd,
   input  logic       regwrite,
   input  logic [4:0] src,
   input  logic       uses,
   output logic       hit
);

   assign hit = valid & regwrite & (rd != REG_ZERO) & uses & (src == rd);

endmodule

// File: rtl/hazard_forward_unit.sv
// Registered EX operand-forward selects plus load-use / branch-in-ID stall
// control, tracking the instructions currently in EX and MEM.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_is_branch,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic [4:0]       id_rd,
   input  logic             mem_busy,
   output logic [1:0]       forwardOp1,
   output logic [1:0]       forwardOp2,
   output logic             stall,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_count
);

   stage_info_t ex_q;
   mem_info_t   mem_q;
   logic        hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
   logic        load_use, branch_haz, hazard, advance;

   hazard_match u_ex_rs (
      .valid(ex_q.valid), .rd(ex_q.rd), .regwrite(ex_q.regwrite),
      .src(id_rs), .uses(id_uses_rs), .hit(hit_ex_rs)
   );
   hazard_match u_ex_rt (
      .valid(ex_q.valid), .rd(ex_q.rd), .regwrite(ex_q.regwrite),
      .src(id_rt), .uses(id_uses_rt), .hit(hit_ex_rt)
   );
   hazard_match u_mem_rs (
      .valid(mem_q.valid), .rd(mem_q.rd), .regwrite(mem_q.regwrite),
      .src(id_rs), .uses(id_uses_rs), .hit(hit_mem_rs)
   );
   hazard_match u_mem_rt (
      .valid(mem_q.valid), .rd(mem_q.rd), .regwrite(mem_q.regwrite),
      .src(id_rt), .uses(id_uses_rt), .hit(hit_mem_rt)
   );

   // Branches compare register-file values in ID, so any in-flight producer
   // must drain; ALU consumers only wait on a load still in EX.
   assign load_use   = id_valid & ~id_is_branch & ex_q.memread & (hit_ex_rs | hit_ex_rt);
   assign branch_haz = id_valid & id_is_branch &
                       (hit_ex_rs | hit_ex_rt | hit_mem_rs | hit_mem_rt);
   assign hazard     = load_use | branch_haz;
   assign stall      = mem_busy | hazard;
   assign bubble     = hazard & ~mem_busy;
   assign advance    = ~mem_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q       <= '0;
         mem_q      <= '0;
         forwardOp1 <= FWD_NONE;
         forwardOp2 <= FWD_NONE;
      end else if (advance) begin
         mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
         if (bubble)
            ex_q <= '0;
         else
            ex_q <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
         if (bubble || !id_valid) begin
            forwardOp1 <= FWD_NONE;
            forwardOp2 <= FWD_NONE;
         end else begin
            forwardOp1 <= fwd_sel(hit_ex_rs, hit_mem_rs);
            forwardOp2 <= fwd_sel(hit_ex_rt, hit_mem_rt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_count <= '0;
      else if (stall && stall_count != {CNT_W{1'b1}})
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed cycle-by-cycle vectors for the hazard/forwarding unit, plus a
// saturation sequence on a narrow-counter instance.
module tb_hazard_forward_unit;

   logic        clk = 1'b0;
   logic        rst, id_valid, id_uses_rs, id_uses_rt, id_is_branch;
   logic        id_regwrite, id_memread, mem_busy;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [1:0]  fwd1, fwd2, s_fwd1, s_fwd2;
   logic        stall, bubble, s_stall, s_bubble;
   logic [31:0] cnt;
   logic [2:0]  s_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_forward_unit #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_rd(id_rd),
      .mem_busy(mem_busy), .forwardOp1(fwd1), .forwardOp2(fwd2),
      .stall(stall), .bubble(bubble), .stall_count(cnt)
   );

   hazard_forward_unit #(.CNT_W(3)) u_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_rd(id_rd),
      .mem_busy(mem_busy), .forwardOp1(s_fwd1), .forwardOp2(s_fwd2),
      .stall(s_stall), .bubble(s_bubble), .stall_count(s_cnt)
   );

   typedef struct {
      logic       v;
      logic [4:0] rs, rt, rd;
      logic       urs, urt, br, rw, mr;
   } instr_t;

   typedef struct {
      logic       rst, busy;
      instr_t     ins;
      logic [1:0] e1, e2;
      logic       es, eb;
      int         ecnt;
   } vec_t;

   vec_t vecs[$];

   function automatic instr_t nop();
      instr_t i = '{v: 1'b0, rs: 5'd0, rt: 5'd0, rd: 5'd0, urs: 1'b0, urt: 1'b0,
                    br: 1'b0, rw: 1'b0, mr: 1'b0};
      return i;
   endfunction

   function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      instr_t i = '{v: 1'b1, rs: rs, rt: rt, rd: rd, urs: 1'b1, urt: 1'b1,
                    br: 1'b0, rw: 1'b1, mr: 1'b0};
      return i;
   endfunction

   function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs);
      instr_t i = '{v: 1'b1, rs: rs, rt: 5'd0, rd: rd, urs: 1'b1, urt: 1'b0,
                    br: 1'b0, rw: 1'b1, mr: 1'b1};
      return i;
   endfunction

   function automatic instr_t beq(input logic [4:0] rs, input logic [4:0] rt);
      instr_t i = '{v: 1'b1, rs: rs, rt: rt, rd: 5'd0, urs: 1'b1, urt: 1'b1,
                    br: 1'b1, rw: 1'b0, mr: 1'b0};
      return i;
   endfunction

   task automatic add(input instr_t ins, input logic r, input logic b, input logic [1:0] e1,
                      input logic [1:0] e2, input logic es, input logic eb, input int ecnt);
      vec_t x;
      x.rst = r; x.busy = b; x.ins = ins; x.e1 = e1; x.e2 = e2;
      x.es = es; x.eb = eb; x.ecnt = ecnt;
      vecs.push_back(x);
   endtask

   task automatic drive(input instr_t i, input logic r, input logic b);
      rst = r; mem_busy = b;
      id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
      id_uses_rs = i.urs; id_uses_rt = i.urt; id_is_branch = i.br;
      id_regwrite = i.rw; id_memread = i.mr;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   initial begin
      // ---- vectors: ID instruction, rst, busy, fwd1, fwd2, stall, bubble, count
      // forwarding from EX/MEM
      add(alu(5'd3, 5'd1, 5'd2),  0, 0, 0, 0, 0, 0, 0);
      add(alu(5'd7, 5'd3, 5'd1),  0, 0, 0, 0, 0, 0, 0);
      add(nop(),                  0, 0, 2, 0, 0, 0, 0);
      add(nop(),                  0, 0, 0, 0, 0, 0, 0);
      // forwarding from WB on rt
      add(alu(5'd3, 5'd1, 5'd2),  0, 0, 0, 0, 0, 0, 0);
      add(nop(),                  0, 0, 0, 0, 0, 0, 0);
      add(alu(5'd8, 5'd1, 5'd3),  0, 0, 0, 0, 0, 0, 0);
      add(nop(),                  0, 0, 0, 1, 0, 0, 0);
      // EX/MEM priority over WB
      add(alu(5'd3, 5'd1, 5'd2),  0, 0, 0, 0, 0, 0, 0);
      add(alu(5'd3, 5'd1, 5'd2),  0, 0, 0, 0, 0, 0, 0);
      add(alu(5'd9, 5'd3, 5'd1),  0, 0, 0, 0, 0, 0, 0);
      add(nop(),                  0, 0, 2, 0, 0, 0, 0);
      add(nop(),                  0, 0, 0, 0, 0, 0, 0);
      // load-use: one stall, then WB forward
      add(lw(5'd5, 5'd1),         0, 0, 0, 0, 0, 0, 0);
      add(alu(5'd6, 5'd5, 5'd2),  0, 0, 0, 0, 1, 1, 0);
      add(alu(5'd6, 5'd5, 5'd2),  0, 0, 0, 0, 0, 0, 1);
      add(nop(),                  0, 0, 1, 0, 0, 0, 1);
      // branch after ALU producer: two stalls
      add(alu(5'd4, 5'd1, 5'd2),  0, 0, 0, 0, 0, 0, 1);
      add(beq(5'd4, 5'd1),        0, 0, 0, 0, 1, 1, 1);
      add(beq(5'd4, 5'd1),        0, 0, 0, 0, 1, 1, 2);
      add(beq(5'd4, 5'd1),        0, 0, 0, 0, 0, 0, 3);
      // register 0 never matches
      add(alu(5'd0, 5'd1, 5'd2),  0, 0, 0, 0, 0, 0, 3);
      add(alu(5'd10, 5'd0, 5'd0), 0, 0, 0, 0, 0, 0, 3);
      add(beq(5'd0, 5'd0),        0, 0, 0, 0, 0, 0, 3);
      add(nop(),                  0, 0, 0, 0, 0, 0, 3);
      // load-use under mem_busy, then reset mid-stall
      add(lw(5'd5, 5'd1),         0, 0, 0, 0, 0, 0, 3);
      add(alu(5'd6, 5'd5, 5'd2),  0, 1, 0, 0, 1, 0, 3);
      add(alu(5'd6, 5'd5, 5'd2),  0, 1, 0, 0, 1, 0, 4);
      add(alu(5'd6, 5'd5, 5'd2),  0, 1, 0, 0, 1, 0, 5);
      add(alu(5'd6, 5'd5, 5'd2),  1, 0, 0, 0, 1, 1, 6);
      add(alu(5'd6, 5'd5, 5'd2),  0, 0, 0, 0, 0, 0, 0);
      // nonzero forward code held across mem_busy
      add(alu(5'd3, 5'd1, 5'd2),  0, 0, 0, 0, 0, 0, 0);
      add(alu(5'd11, 5'd3, 5'd1), 0, 0, 0, 0, 0, 0, 0);
      add(nop(),                  0, 1, 2, 0, 1, 0, 0);
      add(nop(),                  0, 1, 2, 0, 1, 0, 1);
      add(nop(),                  0, 0, 2, 0, 0, 0, 2);
      add(nop(),                  0, 0, 0, 0, 0, 0, 2);

      // ---- reset
      drive(nop(), 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(nop(), 1'b0, 1'b0);
      #1;
      chk("reset_fwd1", fwd1, 0);
      chk("reset_fwd2", fwd2, 0);
      chk("reset_stall", stall, 0);
      chk("reset_bubble", bubble, 0);
      chk("reset_count", cnt, 0);
      chk("reset_sat_count", s_cnt, 0);

      // ---- table
      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         drive(vecs[k].ins, vecs[k].rst, vecs[k].busy);
         #1;
         chk($sformatf("v%0d_fwd1", k), fwd1, vecs[k].e1);
         chk($sformatf("v%0d_fwd2", k), fwd2, vecs[k].e2);
         chk($sformatf("v%0d_stall", k), stall, vecs[k].es);
         chk($sformatf("v%0d_bubble", k), bubble, vecs[k].eb);
         chk($sformatf("v%0d_count", k), cnt, vecs[k].ecnt);
      end

      // ---- counter saturation: 10 busy cycles on top of 2 earlier stalls
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         drive(nop(), 1'b0, 1'b1);
      end
      @(negedge clk);
      drive(nop(), 1'b0, 1'b0);
      #1;
      chk("sat_count_wide", cnt, 12);
      chk("sat_count_narrow", s_cnt, 7);
      chk("sat_stall_released", stall, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
